// File: rtl/clk_div.sv
// clk_div: integer clock divider producing a 50 % duty slow clock and a
// matching single-cycle strobe in the CLOCK domain.
//
// Ports (positional order is fixed: CLOCK, slowclock first):
//   CLOCK     in   system clock, all logic on the rising edge
//   slowclock out  divided clock, period DIVISOR CLOCK cycles, flop output
//   RESET     in   synchronous active-high reset
//   tick      out  one CLOCK-cycle pulse in the cycle slowclock becomes 1
//
// DIVISOR must be even and >= 2. CW is derived from DIVISOR and should not
// be overridden.
module clk_div #(
  parameter int DIVISOR = 100_000_000,
  parameter int CW      = ($clog2(DIVISOR / 2) < 1) ? 1 : $clog2(DIVISOR / 2)
) (
  input  logic CLOCK,
  output logic slowclock,
  input  logic RESET,
  output logic tick
);

  localparam int HALF = DIVISOR / 2;

  if ((DIVISOR < 2) || ((DIVISOR % 2) != 0)) begin : g_bad_divisor
    $error("clk_div: DIVISOR must be even and >= 2");
  end

  localparam logic [CW-1:0] TERM = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          slow_q, slow_d;
  logic          tick_q, tick_d;
  logic          at_term;

  // Exact compare: the counter restarts at HALF-1 and never wraps through 2^CW.
  assign at_term = (cnt_q == TERM);

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    slow_d = slow_q;
    tick_d = 1'b0;
    if (at_term) begin
      cnt_d  = '0;
      slow_d = ~slow_q;
      // Strobe only on the half-period that takes slowclock from 0 to 1.
      tick_d = ~slow_q;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt_q  <= '0;
      slow_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      slow_q <= slow_d;
      tick_q <= tick_d;
    end
  end

  assign slowclock = slow_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_clk_div.sv
module tb_clk_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s10, t10, s2, t2;

  always #5 clk = ~clk;

  clk_div #(.DIVISOR(10)) u_div10 (
    .CLOCK(clk), .slowclock(s10), .RESET(rst), .tick(t10)
  );

  clk_div #(.DIVISOR(2)) u_div2 (
    .CLOCK(clk), .slowclock(s2), .RESET(rst), .tick(t2)
  );

  typedef struct packed {
    logic        s10;
    logic        t10;
    logic        s2;
    logic        t2;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned k      = 0;   // non-reset edges since the last reset edge
  int unsigned cyc    = 0;
  bit          win    = 0;
  int          rises10 = 0;
  int          ticks10 = 0;

  // Reference: after k free-running edges, slowclock is in half-period k/H,
  // high in odd half-periods; tick marks the first edge of each high half.
  function automatic logic ref_slow(input int unsigned kk, input int unsigned h);
    return ((kk / h) % 2) == 1;
  endfunction

  function automatic logic ref_tick(input int unsigned kk, input int unsigned h);
    return (kk > 0) && ((kk % (2 * h)) == h);
  endfunction

  task automatic chk(input string name, input int unsigned c, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b expected %b", name, c, act, exp);
    end
  endtask

  // Drive RESET for the next edge and queue what that edge must produce.
  task automatic step(input logic r);
    exp_t e;
    @(negedge clk);
    rst = r;
    if (r) k = 0;
    else   k = k + 1;
    cyc = cyc + 1;
    e.s10 = ref_slow(k, 5);
    e.t10 = ref_tick(k, 5);
    e.s2  = ref_slow(k, 1);
    e.t2  = ref_tick(k, 1);
    e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  // Monitor: every edge presents a result; pop and compare.
  initial begin
    exp_t e;
    logic p10;
    p10 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("slow10", e.cyc, s10, e.s10);
        chk("tick10", e.cyc, t10, e.t10);
        chk("slow2",  e.cyc, s2,  e.s2);
        chk("tick2",  e.cyc, t2,  e.t2);
        if (win && s10 && !p10) rises10++;
        if (win && t10) ticks10++;
        p10 = s10;
      end
    end
  end

  initial begin
    int hold;
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 60; i++) step(1'b0);

    // Random reset pulses of random length at random phases.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        hold = $urandom_range(1, 4);
        for (int j = 0; j < hold; j++) step(1'b1);
      end else begin
        step(1'b0);
      end
    end

    // Long free run: exactly one rise and one tick per 10 edges.
    step(1'b1);
    win = 1;
    for (int i = 0; i < 1000; i++) step(1'b0);
    @(posedge clk);
    #2;
    win = 0;

    checks++;
    if (rises10 != 100) begin
      errors++;
      $display("FAIL rises10 got %0d expected 100", rises10);
    end
    checks++;
    if (ticks10 != 100) begin
      errors++;
      $display("FAIL ticks10 got %0d expected 100", ticks10);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
